memory_port_arbiter: RTL
========================

Name: memory_port_arbiter

Overview:
- Shares one single-port unified instruction/data RAM between two requesters: the instruction-fetch port (IF) and the memory-access stage port (MEM).
- Serialises accesses and sequences RAM timing for a fixed read latency.
- Returns read data and a one-cycle Ack to the granted requester.
- Sits between the pipeline's fetch/memory stages and the RAM. Pipeline stall logic holds a stage while its Req is high and Ack is low.

Parameters:
DATA_WIDTH, 20, width of instruction/data words
ADDR_WIDTH, 20, width of RAM addresses
MEM_LATENCY, 2, cycles from the Ram_Enable cycle to Ram_ReadData valid; legal range 1..15
STARVE_LIMIT, 3, consecutive MEM grants allowed while IF_Req is waiting before IF is forced; legal range 1..15

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-low reset
IF_Req  in  1  fetch read request; held until IF_Ack
IF_Address  in  ADDR_WIDTH  fetch address; stable while IF_Req is high
IF_Data  out  DATA_WIDTH  fetched word; valid in the IF_Ack cycle
IF_Ack  out  1  one-cycle completion pulse to IF
MEM_Req  in  1  data request; held until MEM_Ack
MEM_WriteEnable  in  1  1 = write, 0 = read
MEM_Address  in  ADDR_WIDTH  data address
MEM_WriteData  in  DATA_WIDTH  write data
MEM_ReadData  out  DATA_WIDTH  read word; valid in the MEM_Ack cycle
MEM_Ack  out  1  one-cycle completion pulse to MEM
Ram_Enable  out  1  RAM access strobe, one cycle per transaction
Ram_WriteEnable  out  1  RAM write strobe; only ever high together with Ram_Enable
Ram_Address  out  ADDR_WIDTH  RAM address
Ram_WriteData  out  DATA_WIDTH  RAM write data
Ram_ReadData  in  DATA_WIDTH  RAM read data
Busy  out  1  high when state is not IDLE
Grant_Owner  out  1  0 = IF, 1 = MEM; meaningful only while Busy is high

Behaviour:
- Reset (Reset=0 at a rising edge):
  - State goes to IDLE; wait counter and starve counter clear to 0.
  - Every output is registered and resets to 0.
  - Reset applied mid-transaction aborts it: no Ack is ever produced for it, Ram strobes drop in the next cycle, and the requester must re-request.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: arbitrate on the registered-sampled Req lines.
  - MEM has priority.
  - Exception: IF wins when starve_cnt == STARVE_LIMIT and IF_Req is high.
  - On a grant, latch owner, address, write-data and write flag, then go to ISSUE.
  - No Req high: stay in IDLE.
- ISSUE (one cycle):
  - Ram_Enable=1, Ram_Address and Ram_WriteData driven from the latched values.
  - Ram_WriteEnable=1 only for a MEM write.
  - Write: go to RESPOND. Read: load wait_cnt=MEM_LATENCY and go to WAIT.
- WAIT:
  - Ram_Enable=0; wait_cnt decrements each cycle.
  - When wait_cnt reaches 1, capture Ram_ReadData at that edge and go to RESPOND.
  - Result: Ram_ReadData is sampled in cycle ISSUE+MEM_LATENCY.
- RESPOND (one cycle):
  - The owner's Ack=1 and its data output holds the captured word.
  - For a write, the data output holds its previous value.
  - Next state is IDLE.
- Latency with Req first high in IDLE cycle T:
  - Read: Ack in cycle T+2+MEM_LATENCY.
  - Write: Ack in cycle T+2.
  - Back-to-back read period: MEM_LATENCY+3 cycles.
- Ack hygiene: only the granted requester's Ack fires. IF_Ack and MEM_Ack are never high together.
- Data outputs: IF_Data and MEM_ReadData hold their last captured value between Acks.
- Starve counter:
  - On a MEM grant while IF_Req is high: increment, saturating at STARVE_LIMIT.
  - On any IF grant: clear to 0.
  - On a MEM grant while IF_Req is low: clear to 0.
- Req drop mid-transaction (protocol violation): the transaction still completes and Ack is still pulsed.
- Req still high in the cycle after Ack: treated as a new request.
- Inputs changing during a transaction: ignored; the latched values are used.
- Busy: 1 in ISSUE, WAIT and RESPOND.
- Grant_Owner: updated on each grant and held until the next grant.

Test Plan:
- IF read, MEM_LATENCY=2: IF_Req at T with IF_Address=0x00010 and RAM[0x00010]=0xABCDE -> Ram_Enable only in T+1; IF_Ack and IF_Data=0xABCDE at T+4; MEM_Ack stays 0.
- MEM write: MEM_Req=1, MEM_WriteEnable=1, addr 0x00200, data 0x12345 -> Ram_Enable=Ram_WriteEnable=1 at T+1 with that address and data; MEM_Ack at T+2; a subsequent read of 0x00200 returns 0x12345.
- Simultaneous IF_Req and MEM_Req reads, MEM_LATENCY=2 -> MEM_Ack at T+4, then IF granted in the following IDLE cycle; IF_Ack at T+9.
- Starvation, STARVE_LIMIT=3: IF_Req held while MEM_Req is re-asserted after every Ack -> exactly 3 MEM Acks, then an IF Ack, then MEM resumes; starve_cnt returns to 0.
- Reset mid-access: Reset=0 during WAIT -> next cycle all outputs 0 and state IDLE; no Ack for the aborted read; a re-request after Reset=1 completes normally.
- Boundary MEM_LATENCY=1 -> read Ack at T+3 with Ram_ReadData sampled in cycle T+2.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-port RAM between fetch (IF) and memory-stage (MEM) requesters; MEM wins unless IF has waited STARVE_LIMIT grants.
// Read Ack lands MEM_LATENCY+2 cycles after Req is sampled, a write Ack 2 cycles after; a requester is stalled by holding Req until its Ack.
module memory_port_arbiter #(
    parameter int DATA_WIDTH   = 20,
    parameter int ADDR_WIDTH   = 20,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  IF_Req,
    input  logic [ADDR_WIDTH-1:0] IF_Address,
    output logic [DATA_WIDTH-1:0] IF_Data,
    output logic                  IF_Ack,
    input  logic                  MEM_Req,
    input  logic                  MEM_WriteEnable,
    input  logic [ADDR_WIDTH-1:0] MEM_Address,
    input  logic [DATA_WIDTH-1:0] MEM_WriteData,
    output logic [DATA_WIDTH-1:0] MEM_ReadData,
    output logic                  MEM_Ack,
    output logic                  Ram_Enable,
    output logic                  Ram_WriteEnable,
    output logic [ADDR_WIDTH-1:0] Ram_Address,
    output logic [DATA_WIDTH-1:0] Ram_WriteData,
    input  logic [DATA_WIDTH-1:0] Ram_ReadData,
    output logic                  Busy,
    output logic                  Grant_Owner
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);
    localparam logic [3:0] STARVE  = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] waitCnt;
    logic [3:0] starveCnt;
    logic       isWrite;
    logic       ifForced;

    // IF only overrides MEM once it has been passed over STARVE_LIMIT times in a row.
    assign ifForced = IF_Req && (starveCnt == STARVE);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state           <= S_IDLE;
            waitCnt         <= '0;
            starveCnt       <= '0;
            isWrite         <= 1'b0;
            IF_Data         <= '0;
            IF_Ack          <= 1'b0;
            MEM_ReadData    <= '0;
            MEM_Ack         <= 1'b0;
            Ram_Enable      <= 1'b0;
            Ram_WriteEnable <= 1'b0;
            Ram_Address     <= '0;
            Ram_WriteData   <= '0;
            Busy            <= 1'b0;
            Grant_Owner     <= 1'b0;
        end else begin
            IF_Ack          <= 1'b0;
            MEM_Ack         <= 1'b0;
            Ram_Enable      <= 1'b0;
            Ram_WriteEnable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MEM_Req && !ifForced) begin
                        Grant_Owner     <= 1'b1;
                        isWrite         <= MEM_WriteEnable;
                        Ram_Address     <= MEM_Address;
                        Ram_WriteData   <= MEM_WriteData;
                        Ram_Enable      <= 1'b1;
                        Ram_WriteEnable <= MEM_WriteEnable;
                        Busy            <= 1'b1;
                        state           <= S_ISSUE;
                        if (!IF_Req)
                            starveCnt <= '0;
                        else if (starveCnt != STARVE)
                            starveCnt <= starveCnt + 4'd1;
                    end else if (IF_Req) begin
                        Grant_Owner <= 1'b0;
                        isWrite     <= 1'b0;
                        Ram_Address <= IF_Address;
                        Ram_Enable  <= 1'b1;
                        Busy        <= 1'b1;
                        starveCnt   <= '0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (isWrite) begin
                        MEM_Ack <= 1'b1;
                        state   <= S_RESPOND;
                    end else begin
                        waitCnt <= LATENCY;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        if (Grant_Owner) begin
                            MEM_ReadData <= Ram_ReadData;
                            MEM_Ack      <= 1'b1;
                        end else begin
                            IF_Data <= Ram_ReadData;
                            IF_Ack  <= 1'b1;
                        end
                        state <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
